gdb_rsp_rx: RTL and testbench
=============================

# gdb_rsp_rx

Receive-side packet controller for the GDB Remote Serial Protocol stub. It sits between the socket byte stream (bytes delivered from the DPI socket receive path) and the command decoder. It frames `$payload#cs` packets, un-escapes the payload into a local buffer, and validates the checksum. It then sequences the `+`/`-` acknowledge byte onto the socket transmit path before handing the packet to the decoder, and it reports out-of-packet Ctrl-C as a break request.

## Interface
- `BUF_DEPTH`, default 512: payload buffer size in bytes. Must be a power of two, ≥4.
- `clk  in  1`: clock.
- `rst_n  in  1`: reset, asynchronous, active-low.
- `rx_vld  in  1` / `rx_rdy  out  1` / `rx_dat  in  8`: byte stream from the socket.
- `tx_vld  out  1` / `tx_rdy  in  1` / `tx_dat  out  8`: ack/nack byte to the socket.
- `noack  in  1`: no-ack mode (QStartNoAckMode). Sampled when a packet terminates.
- `pkt_vld  out  1` / `pkt_rdy  in  1`: a complete, good packet is available.
- `pkt_len  out  $clog2(BUF_DEPTH+1)`: payload length after un-escaping.
- `pkt_adr  in  $clog2(BUF_DEPTH)` / `pkt_dat  out  8`: buffer read port.
- `brk  out  1`: one-cycle pulse on 0x03 received in IDLE.
- `err_chk  out  1`: one-cycle pulse on checksum mismatch or a non-hex checksum digit.
- `err_ovf  out  1`: one-cycle pulse when a packet exceeded `BUF_DEPTH`.

## Operation
- A byte transfers on a rising edge with `rx_vld && rx_rdy`. At most one byte per cycle.
- `rx_rdy` is 1 in IDLE, DATA, ESC, CHK1 and CHK2. It is 0 in ACK and HOLD.
- The checksum is the 8-bit modulo-256 sum of raw bytes strictly between `$` and `#`. This includes `}` and the escaped byte before un-escaping.
- State transitions:
  - IDLE:
    - `$` (0x24) → DATA; clear len and sum.
    - 0x03 → pulse `brk`, stay.
    - Any other byte (including `+`, `-`) is discarded.
  - DATA:
    - `#` (0x23) → CHK1.
    - `}` (0x7d) → ESC; add to sum.
    - `$` → resync: clear len and sum, stay in DATA.
    - Any other byte: store at `len`, `len++`, add to sum.
  - ESC: store `byte ^ 0x20`, add the raw byte to sum, → DATA. A `$` in ESC is data, not resync.
  - Store with `len == BUF_DEPTH`: do not write, set the overflow flag, keep parsing.
  - CHK1: high nibble → CHK2.
  - CHK2: low nibble. Valid hex digits are `0-9`, `a-f`, `A-F`.
  - Evaluation on CHK2 accept:
    - The packet is good only if both digits are hex, the value equals sum, and there is no overflow.
    - Good, `noack=0` → ACK with `tx_dat='+'` (0x2b).
    - Good, `noack=1` → HOLD.
    - Bad, `noack=0` → ACK with `tx_dat='-'` (0x2d) and the matching err pulse. After the handshake → IDLE.
    - Bad, `noack=1` → err pulse, → IDLE with no tx.
    - Overflow takes precedence: pulse `err_ovf` only, not `err_chk`.
  - ACK: `tx_vld=1`, `tx_dat` held stable until `tx_rdy`. On the handshake → HOLD (good) or IDLE (bad).
  - HOLD: `pkt_vld=1`, `pkt_len` stable, buffer readable. On `pkt_vld && pkt_rdy` → IDLE.
- `pkt_dat` returns `buf[pkt_adr]` one cycle after `pkt_adr` is presented. The read is valid in any state, but the contents are only guaranteed in HOLD.

## Timing
- Reset values:
  - State IDLE.
  - `rx_rdy=0` while `rst_n=0`, then 1 from the first cycle after release.
  - `tx_vld=0`, `tx_dat=0x00`, `pkt_vld=0`, `pkt_len=0`, `brk=0`, `err_chk=0`, `err_ovf=0`.
  - Buffer contents are undefined.
- Reset mid-packet discards the partial packet. An asserted `tx_vld` or `pkt_vld` drops immediately (asynchronous).
- `brk`, `err_chk`, `err_ovf` pulse in the cycle after the triggering byte transfer.
- `tx_vld` rises in the cycle after the CHK2 transfer.
- `pkt_vld` rises in the cycle after the `tx` handshake, or in the cycle after the CHK2 transfer when `noack=1`.
- `rx_rdy` returns to 1 in the cycle after the `pkt` handshake (or after the `-` handshake).
- Best-case turnaround for a 1-byte payload (5 bytes on the wire, `tx_rdy=1`, `pkt_rdy=1`): 8 cycles from `$` to next `rx_rdy`.

## Structure
- Package `gdb_rsp_pkg`:
  - Character constants `$ # } + -`, 0x03, and the escape XOR 0x20.
  - State enum.
  - Function `hex2nib` returning a valid bit and a 4-bit value.
- Sub-module `gdb_rsp_buf`: simple dual-port RAM, `BUF_DEPTH`×8, one write port, synchronous read port.

## Test plan
- `$g#67`:
  - `tx` emits 0x2b.
  - Then `pkt_vld` with `pkt_len=1` and `buf[0]=0x67`.
  - No err pulse.
- Bad checksum:
  - `$g#00` → `tx` emits 0x2d, `err_chk` pulses, no `pkt_vld`, back in IDLE.
  - `$g#zz` → same response.
- Escape: `$}]#da` → 0x2b, `pkt_len=1`, `buf[0]=0x7d`.
- `tx_rdy=0` for 10 cycles: `tx_vld` and `tx_dat` stay stable and `rx_rdy=0`.
- 0x03 in IDLE → `brk` high exactly one cycle, no `tx`. The same byte inside a packet is stored as data.
- Overflow with `BUF_DEPTH=4`: `$abcde#ef` → 0x2d, `err_ovf` pulse, no `err_chk`, no `pkt_vld`.
- Resync and no-ack:
  - `noack=1`, `$ab$g#67` → no `tx`, `pkt_len=1`, `buf[0]=0x67`.
  - Then `$a` followed by `rst_n` low → outputs reset.
  - Then `$g#67` → exactly one packet.

Source files
------------

// File: rtl/gdb_rsp_pkg.sv
// Shared constants, FSM state encoding and hex-digit decoding for the GDB RSP
// receive path.
package gdb_rsp_pkg;

  localparam logic [7:0] CH_SOP  = 8'h24;
  localparam logic [7:0] CH_EOP  = 8'h23;
  localparam logic [7:0] CH_ESC  = 8'h7d;
  localparam logic [7:0] CH_ACK  = 8'h2b;
  localparam logic [7:0] CH_NAK  = 8'h2d;
  localparam logic [7:0] CH_BRK  = 8'h03;
  localparam logic [7:0] ESC_XOR = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DATA = 3'd1,
    ST_ESC  = 3'd2,
    ST_CHK1 = 3'd3,
    ST_CHK2 = 3'd4,
    ST_ACK  = 3'd5,
    ST_HOLD = 3'd6
  } state_t;

  typedef struct packed {
    logic       vld;
    logic [3:0] val;
  } nib_t;

  function automatic nib_t hex2nib(input logic [7:0] c);
    nib_t n;
    n.vld = 1'b1;
    if (c >= 8'h30 && c <= 8'h39) begin
      n.val = c[3:0];
    end else if ((c >= 8'h61 && c <= 8'h66) || (c >= 8'h41 && c <= 8'h46)) begin
      n.val = c[3:0] + 4'd9;
    end else begin
      n.vld = 1'b0;
      n.val = 4'h0;
    end
    return n;
  endfunction

endpackage

// File: rtl/gdb_rsp_buf.sv
// Payload buffer: simple dual-port RAM with one write port and a
// registered read port (data appears one cycle after the address).
module gdb_rsp_buf #(
  parameter int unsigned DEPTH = 512,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_adr_i,
  input  logic [7:0]    wr_dat_i,
  input  logic [AW-1:0] rd_adr_i,
  output logic [7:0]    rd_dat_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rd_dat_q;

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_adr_i] <= wr_dat_i;
    end
  end

  // Synchronous read port.
  always_ff @(posedge clk) begin
    rd_dat_q <= mem_q[rd_adr_i];
  end

  assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/gdb_rsp_rx.sv
// GDB RSP receive controller: frames $payload#cs, un-escapes into the buffer,
// checks the checksum, sends +/- and hands good packets to the decoder.
module gdb_rsp_rx
  import gdb_rsp_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 512,
  localparam int unsigned AW = $clog2(BUF_DEPTH),
  localparam int unsigned LW = $clog2(BUF_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx_vld,
  output logic          rx_rdy,
  input  logic [7:0]    rx_dat,
  output logic          tx_vld,
  input  logic          tx_rdy,
  output logic [7:0]    tx_dat,
  input  logic          noack,
  output logic          pkt_vld,
  input  logic          pkt_rdy,
  output logic [LW-1:0] pkt_len,
  input  logic [AW-1:0] pkt_adr,
  output logic [7:0]    pkt_dat,
  output logic          brk,
  output logic          err_chk,
  output logic          err_ovf
);

  state_t        state_q;
  logic [LW-1:0] len_q;
  logic [7:0]    sum_q;
  logic          ovf_q;
  logic [3:0]    hi_q;
  logic          hi_ok_q;
  logic          good_q;
  logic          rx_rdy_q;
  logic          tx_vld_q;
  logic [7:0]    tx_dat_q;
  logic          pkt_vld_q;
  logic [LW-1:0] pkt_len_q;
  logic          brk_q;
  logic          err_chk_q;
  logic          err_ovf_q;

  logic          rx_fire_s;
  logic          full_s;
  logic          data_byte_s;
  logic          wr_en_s;
  logic [7:0]    wr_dat_s;
  nib_t          nib_s;
  logic          pkt_good_s;

  // Byte classification, buffer write strobe and checksum verdict.
  always_comb begin
    rx_fire_s   = rx_vld && rx_rdy_q;
    full_s      = (len_q == LW'(BUF_DEPTH));
    nib_s       = hex2nib(rx_dat);
    pkt_good_s  = hi_ok_q && nib_s.vld && ({hi_q, nib_s.val} == sum_q) && !ovf_q;
    data_byte_s = (rx_dat != CH_EOP) && (rx_dat != CH_ESC) && (rx_dat != CH_SOP);
    wr_en_s     = 1'b0;
    wr_dat_s    = rx_dat;
    if (rx_fire_s && !full_s) begin
      case (state_q)
        ST_DATA: begin
          wr_en_s  = data_byte_s;
          wr_dat_s = rx_dat;
        end
        ST_ESC: begin
          wr_en_s  = 1'b1;
          wr_dat_s = rx_dat ^ ESC_XOR;
        end
        default: begin
          wr_en_s  = 1'b0;
          wr_dat_s = rx_dat;
        end
      endcase
    end else begin
      wr_en_s  = 1'b0;
      wr_dat_s = rx_dat;
    end
  end

  // Packet FSM with registered handshake and pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      sum_q     <= 8'h00;
      ovf_q     <= 1'b0;
      hi_q      <= 4'h0;
      hi_ok_q   <= 1'b0;
      good_q    <= 1'b0;
      rx_rdy_q  <= 1'b0;
      tx_vld_q  <= 1'b0;
      tx_dat_q  <= 8'h00;
      pkt_vld_q <= 1'b0;
      pkt_len_q <= '0;
      brk_q     <= 1'b0;
      err_chk_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      brk_q     <= 1'b0;
      err_chk_q <= 1'b0;
      err_ovf_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          rx_rdy_q <= 1'b1;
          if (rx_fire_s && rx_dat == CH_SOP) begin
            state_q <= ST_DATA;
            len_q   <= '0;
            sum_q   <= 8'h00;
            ovf_q   <= 1'b0;
          end else if (rx_fire_s && rx_dat == CH_BRK) begin
            brk_q <= 1'b1;
          end
        end
        ST_DATA: begin
          if (rx_fire_s) begin
            case (rx_dat)
              CH_EOP: state_q <= ST_CHK1;
              CH_ESC: begin
                state_q <= ST_ESC;
                sum_q   <= sum_q + rx_dat;
              end
              CH_SOP: begin
                len_q <= '0;
                sum_q <= 8'h00;
                ovf_q <= 1'b0;
              end
              default: begin
                sum_q <= sum_q + rx_dat;
                if (full_s) ovf_q <= 1'b1;
                else        len_q <= len_q + LW'(1);
              end
            endcase
          end
        end
        ST_ESC: begin
          if (rx_fire_s) begin
            state_q <= ST_DATA;
            sum_q   <= sum_q + rx_dat;
            if (full_s) ovf_q <= 1'b1;
            else        len_q <= len_q + LW'(1);
          end
        end
        ST_CHK1: begin
          if (rx_fire_s) begin
            state_q <= ST_CHK2;
            hi_q    <= nib_s.val;
            hi_ok_q <= nib_s.vld;
          end
        end
        ST_CHK2: begin
          if (rx_fire_s) begin
            good_q <= pkt_good_s;
            if (pkt_good_s) begin
              pkt_len_q <= len_q;
            end else begin
              // Overflow masks any checksum complaint.
              err_ovf_q <= ovf_q;
              err_chk_q <= !ovf_q;
            end
            if (!noack) begin
              state_q  <= ST_ACK;
              rx_rdy_q <= 1'b0;
              tx_vld_q <= 1'b1;
              tx_dat_q <= pkt_good_s ? CH_ACK : CH_NAK;
            end else if (pkt_good_s) begin
              state_q   <= ST_HOLD;
              rx_rdy_q  <= 1'b0;
              pkt_vld_q <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_ACK: begin
          if (tx_rdy) begin
            tx_vld_q <= 1'b0;
            if (good_q) begin
              state_q   <= ST_HOLD;
              pkt_vld_q <= 1'b1;
            end else begin
              state_q  <= ST_IDLE;
              rx_rdy_q <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (pkt_rdy) begin
            state_q   <= ST_IDLE;
            pkt_vld_q <= 1'b0;
            rx_rdy_q  <= 1'b1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          rx_rdy_q  <= 1'b0;
          tx_vld_q  <= 1'b0;
          pkt_vld_q <= 1'b0;
        end
      endcase
    end
  end

  gdb_rsp_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk      (clk),
    .wr_en_i  (wr_en_s),
    .wr_adr_i (len_q[AW-1:0]),
    .wr_dat_i (wr_dat_s),
    .rd_adr_i (pkt_adr),
    .rd_dat_o (pkt_dat)
  );

  assign rx_rdy  = rx_rdy_q;
  assign tx_vld  = tx_vld_q;
  assign tx_dat  = tx_dat_q;
  assign pkt_vld = pkt_vld_q;
  assign pkt_len = pkt_len_q;
  assign brk     = brk_q;
  assign err_chk = err_chk_q;
  assign err_ovf = err_ovf_q;

endmodule

// File: tb/tb_gdb_rsp_rx.sv
// Directed bench for gdb_rsp_rx with a 4-byte buffer: a vector table of
// whole packets plus hand sequences for stall, turnaround and reset.
module tb_gdb_rsp_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_vld = 1'b0;
  logic       rx_rdy;
  logic [7:0] rx_dat = 8'h00;
  logic       tx_vld;
  logic       tx_rdy = 1'b1;
  logic [7:0] tx_dat;
  logic       noack = 1'b0;
  logic       pkt_vld;
  logic       pkt_rdy = 1'b0;
  logic [2:0] pkt_len;
  logic [1:0] pkt_adr = 2'd3;
  logic [7:0] pkt_dat;
  logic       brk;
  logic       err_chk;
  logic       err_ovf;

  always #5 clk = ~clk;

  gdb_rsp_rx #(.BUF_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_vld(rx_vld), .rx_rdy(rx_rdy), .rx_dat(rx_dat),
    .tx_vld(tx_vld), .tx_rdy(tx_rdy), .tx_dat(tx_dat),
    .noack(noack),
    .pkt_vld(pkt_vld), .pkt_rdy(pkt_rdy), .pkt_len(pkt_len),
    .pkt_adr(pkt_adr), .pkt_dat(pkt_dat),
    .brk(brk), .err_chk(err_chk), .err_ovf(err_ovf)
  );

  int n_assert = 0;
  int n_fail = 0;

  // Event counters observed on the falling edge.
  int mon_tx = 0, mon_pkt = 0, mon_chk = 0, mon_ovf = 0, mon_brk = 0;
  logic [7:0] mon_tx_dat = 8'h00;
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_vld && tx_rdy) begin
        mon_tx     <= mon_tx + 1;
        mon_tx_dat <= tx_dat;
      end
      if (pkt_vld && pkt_rdy) mon_pkt <= mon_pkt + 1;
      if (err_chk) mon_chk <= mon_chk + 1;
      if (err_ovf) mon_ovf <= mon_ovf + 1;
      if (brk)     mon_brk <= mon_brk + 1;
    end
  end

  int s_tx, s_pkt, s_chk, s_ovf, s_brk;

  typedef struct {
    logic [79:0] pkt;
    int          n;
    logic        na;
    int          ntx;
    logic [7:0]  txb;
    int          npkt;
    int          len;
    logic [7:0]  b0;
    int          nchk;
    int          novf;
    int          nbrk;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t mk(input logic [79:0] p, input int n, input logic na,
                              input int ntx, input logic [7:0] txb, input int npkt,
                              input int len, input logic [7:0] b0, input int nchk,
                              input int novf, input int nbrk);
    vec_t v;
    v.pkt = p; v.n = n; v.na = na; v.ntx = ntx; v.txb = txb; v.npkt = npkt;
    v.len = len; v.b0 = b0; v.nchk = nchk; v.novf = novf; v.nbrk = nbrk;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Callers are always at posedge+1 so a raised rx_vld is seen by the next negedge.
  task automatic send_byte(input logic [7:0] b);
    bit done;
    bit rdy;
    done = 1'b0;
    rx_vld = 1'b1;
    rx_dat = b;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      rdy = rx_rdy;
      @(posedge clk);
      #1;
      done = rdy;
    end
    rx_vld = 1'b0;
    if (!done) check("rx_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_pkt(input logic [79:0] p, input int n);
    for (int j = 0; j < n; j++) send_byte(p[(n-1-j)*8 +: 8]);
  endtask

  task automatic snap();
    s_tx = mon_tx; s_pkt = mon_pkt; s_chk = mon_chk; s_ovf = mon_ovf; s_brk = mon_brk;
  endtask

  task automatic finish_pkt(input string tag, input int npkt, input int len, input logic [7:0] b0);
    @(negedge clk);
    check({tag, "_pkt_vld"}, 32'(pkt_vld), 32'(npkt != 0));
    if (pkt_vld) begin
      check({tag, "_pkt_len"}, 32'(pkt_len), 32'(len));
      @(posedge clk); #1;
      pkt_adr = 2'd0;
      @(posedge clk); #1;
      @(negedge clk);
      check({tag, "_buf0"}, 32'(pkt_dat), 32'(b0));
      pkt_adr = 2'd3;
      @(posedge clk); #1;
      pkt_rdy = 1'b1;
      @(posedge clk); #1;
      pkt_rdy = 1'b0;
      @(negedge clk);
    end
    check({tag, "_rx_rdy_idle"}, 32'(rx_rdy), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic deltas(input string tag, input int ntx, input logic [7:0] txb, input int npkt,
                        input int nchk, input int novf, input int nbrk);
    check({tag, "_ntx"}, 32'(mon_tx - s_tx), 32'(ntx));
    if (ntx > 0) check({tag, "_tx_dat"}, 32'(mon_tx_dat), 32'(txb));
    check({tag, "_npkt"}, 32'(mon_pkt - s_pkt), 32'(npkt));
    check({tag, "_err_chk"}, 32'(mon_chk - s_chk), 32'(nchk));
    check({tag, "_err_ovf"}, 32'(mon_ovf - s_ovf), 32'(novf));
    check({tag, "_brk"}, 32'(mon_brk - s_brk), 32'(nbrk));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    tbl[0]  = mk(80'("$g#67"),                 5, 1'b0, 1, 8'h2b, 1, 1, 8'h67, 0, 0, 0);
    tbl[1]  = mk(80'("$g#00"),                 5, 1'b0, 1, 8'h2d, 0, 0, 8'h00, 1, 0, 0);
    tbl[2]  = mk(80'("$g#zz"),                 5, 1'b0, 1, 8'h2d, 0, 0, 8'h00, 1, 0, 0);
    tbl[3]  = mk(80'("$}]#da"),                6, 1'b0, 1, 8'h2b, 1, 1, 8'h7d, 0, 0, 0);
    tbl[4]  = mk(80'("$}]#DA"),                6, 1'b0, 1, 8'h2b, 1, 1, 8'h7d, 0, 0, 0);
    tbl[5]  = mk(80'(8'h03),                   1, 1'b0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1);
    tbl[6]  = mk(80'({"$", 8'h03, "#03"}),     5, 1'b0, 1, 8'h2b, 1, 1, 8'h03, 0, 0, 0);
    tbl[7]  = mk(80'("$ab#c3"),                6, 1'b0, 1, 8'h2b, 1, 2, 8'h61, 0, 0, 0);
    tbl[8]  = mk(80'("+-x"),                   3, 1'b0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0);
    tbl[9]  = mk(80'("$abcde#ef"),             9, 1'b0, 1, 8'h2d, 0, 0, 8'h00, 0, 1, 0);
    tbl[10] = mk(80'("$abcd#8a"),              8, 1'b0, 1, 8'h2b, 1, 4, 8'h61, 0, 0, 0);
    tbl[11] = mk(80'("$ab$g#67"),              8, 1'b1, 0, 8'h00, 1, 1, 8'h67, 0, 0, 0);
    tbl[12] = mk(80'("$g#00"),                 5, 1'b1, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0);
    tbl[13] = mk(80'("$abcde#00"),             9, 1'b1, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0);

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_rdy", 32'(rx_rdy), 32'd0);
    check("rst_tx_vld", 32'(tx_vld), 32'd0);
    check("rst_tx_dat", 32'(tx_dat), 32'h00);
    check("rst_pkt_vld", 32'(pkt_vld), 32'd0);
    check("rst_pkt_len", 32'(pkt_len), 32'd0);
    check("rst_pulses", 32'({brk, err_chk, err_ovf}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_rx_rdy", 32'(rx_rdy), 32'd1);

    for (int i = 0; i < 14; i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      noack = tbl[i].na;
      snap();
      send_pkt(tbl[i].pkt, tbl[i].n);
      repeat (6) @(posedge clk);
      #1;
      finish_pkt(tag, tbl[i].npkt, tbl[i].len, tbl[i].b0);
      deltas(tag, tbl[i].ntx, tbl[i].txb, tbl[i].npkt, tbl[i].nchk, tbl[i].novf, tbl[i].nbrk);
    end

    // Back-pressured ack: tx stays put and rx is blocked.
    noack = 1'b0;
    tx_rdy = 1'b0;
    snap();
    send_pkt(80'("$g#67"), 5);
    @(negedge clk);
    check("stall_tx_rise", 32'({tx_vld, tx_dat}), 32'({1'b1, 8'h2b}));
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check($sformatf("stall_c%0d", k), 32'({tx_vld, tx_dat, rx_rdy, pkt_vld}),
            32'({1'b1, 8'h2b, 1'b0, 1'b0}));
    end
    @(posedge clk); #1;
    tx_rdy = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("stall_pkt_rise", 32'({pkt_vld, tx_vld}), 32'({1'b1, 1'b0}));
    @(posedge clk); #1;
    finish_pkt("stall", 1, 1, 8'h67);
    deltas("stall", 1, 8'h2b, 1, 0, 0, 0);

    // Best-case turnaround with both sinks always ready.
    pkt_rdy = 1'b1;
    snap();
    send_pkt(80'("$g#67"), 5);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      cnt++;
      if (rx_rdy) break;
    end
    check("turnaround_cycles", 32'(5 + cnt), 32'd8);
    @(posedge clk); #1;
    pkt_rdy = 1'b0;
    deltas("turn", 1, 8'h2b, 1, 0, 0, 0);

    // Reset while tx_vld is up drops it asynchronously.
    tx_rdy = 1'b0;
    snap();
    send_pkt(80'("$g#67"), 5);
    @(negedge clk);
    check("pre_rst_tx_vld", 32'(tx_vld), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_tx_vld", 32'({tx_vld, tx_dat, rx_rdy}), 32'd0);
    check("async_pkt_len", 32'(pkt_len), 32'd0);
    tx_rdy = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("async_ntx", 32'(mon_tx - s_tx), 32'd0);

    // Partial packet then reset, then one clean packet.
    noack = 1'b1;
    send_pkt(80'("$a"), 2);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_outs", 32'({rx_rdy, tx_vld, pkt_vld, brk, err_chk, err_ovf}), 32'd0);
    check("mid_rst_len", 32'(pkt_len), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    snap();
    send_pkt(80'("$g#67"), 5);
    repeat (6) @(posedge clk);
    #1;
    finish_pkt("post_rst", 1, 1, 8'h67);
    deltas("post_rst", 0, 8'h00, 1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
